debug_dump_sequencer: RTL

Controller that dumps the MIPS architectural state over the 32-bit UART transmitter after a single start request. It walks the PC, all general-purpose registers and, optionally, data-memory words. For each item it drives the MIPS debug read address ports, captures the returned word and performs one 32-bit UART send handshake. It sits between the debug unit's command decoder, the MIPS debug read ports and the UART TX path, on the divided core clock.

---
 rtl/debug_dump_sequencer.sv | 97 +++++++++
 1 files changed

// File: rtl/debug_dump_sequencer.sv
// debug_dump_sequencer: streams PC, registers and (with DEBUG_DUMP_MEM_EN) data memory over 32-bit UART
module debug_dump_sequencer #(
    parameter int NB_DATA        = 32,
    parameter int NB_REG_ADDRESS = 5,
    parameter int NB_MEM_ADDRESS = 7,
    parameter int N_REGS         = 32,
    parameter int N_MEM_WORDS    = 32
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic                      i_abort,
    input  logic [NB_DATA-1:0]        i_debug_read_pc,
    input  logic [NB_DATA-1:0]        i_debug_read_reg,
    input  logic [NB_DATA-1:0]        i_debug_read_mem,
    input  logic                      i_uart_tx_done,
    output logic [NB_REG_ADDRESS-1:0] o_debug_read_reg_address,
    output logic [NB_MEM_ADDRESS-1:0] o_debug_read_mem_address,
    output logic [NB_DATA-1:0]        o_uart_data_to_send,
    output logic                      o_uart_enable_send_data,
    output logic                      o_busy,
    output logic                      o_done
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD_ADDR, S_CAPTURE, S_SEND, S_WAIT_TX, S_DONE} state_t;
    typedef enum logic [1:0] {P_PC, P_REG, P_MEM} phase_t;
    state_t                    r_state, w_next;
    phase_t                    r_phase;
    logic [NB_REG_ADDRESS-1:0] r_reg_addr;
    logic [NB_DATA-1:0]        r_data;
    logic [NB_DATA-1:0]        w_word;
    logic                      w_abort, w_adv, w_last, w_reg_end;
    assign w_abort   = i_abort && r_state != S_IDLE;
    assign w_adv     = r_state == S_WAIT_TX && i_uart_tx_done && !i_abort;
    assign w_reg_end = r_phase == P_REG && r_reg_addr == NB_REG_ADDRESS'(N_REGS - 1);
`ifdef DEBUG_DUMP_MEM_EN
    logic [NB_MEM_ADDRESS-1:0] r_mem_addr;
    assign w_last = r_phase == P_MEM && r_mem_addr == NB_MEM_ADDRESS'(N_MEM_WORDS - 1);
    assign w_word = r_phase == P_PC ? i_debug_read_pc : r_phase == P_REG ? i_debug_read_reg : i_debug_read_mem;
    assign o_debug_read_mem_address = r_mem_addr;
    always_ff @(posedge i_clock) begin
        if (i_reset || w_abort || (r_state == S_IDLE && i_start))
            r_mem_addr <= '0;
        else if (w_adv && !w_last && r_phase == P_MEM)
            r_mem_addr <= r_mem_addr + NB_MEM_ADDRESS'(1);
    end
`else
    logic w_unused_mem;
    assign w_unused_mem = ^i_debug_read_mem;
    assign w_last = w_reg_end;
    assign w_word = r_phase == P_PC ? i_debug_read_pc : i_debug_read_reg;
    assign o_debug_read_mem_address = '0;
`endif
    always_ff @(posedge i_clock) begin
        r_state <= i_reset ? S_IDLE : w_next;
    end
    always_comb begin
        w_next                  = r_state;
        o_busy                  = r_state != S_IDLE;
        o_done                  = r_state == S_DONE;
        o_uart_enable_send_data = r_state == S_SEND;
        case (r_state)
            S_IDLE:      w_next = i_start ? S_LOAD_ADDR : S_IDLE;
            S_LOAD_ADDR: w_next = S_CAPTURE;
            S_CAPTURE:   w_next = S_SEND;
            S_SEND:      w_next = S_WAIT_TX;
            S_WAIT_TX:   w_next = i_uart_tx_done ? (w_last ? S_DONE : S_LOAD_ADDR) : S_WAIT_TX;
            S_DONE:      w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
        if (w_abort)
            w_next = S_IDLE;
    end
    always_ff @(posedge i_clock) begin
        if (i_reset || w_abort) begin
            r_phase    <= P_PC;
            r_reg_addr <= '0;
            r_data     <= '0;
        end else begin
            if (r_state == S_IDLE && i_start) begin
                r_phase    <= P_PC;
                r_reg_addr <= '0;
            end
            if (r_state == S_CAPTURE)
                r_data <= w_word;
            if (w_adv && !w_last) begin
                if (r_phase == P_PC)
                    r_phase <= P_REG;
                else if (w_reg_end)
                    r_phase <= P_MEM;
                else if (r_phase == P_REG)
                    r_reg_addr <= r_reg_addr + NB_REG_ADDRESS'(1);
            end
        end
    end
    assign o_debug_read_reg_address = r_reg_addr;
    assign o_uart_data_to_send      = r_data;
endmodule
